// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and the data stage.
// One outstanding transaction at a time: IDLE -> BUSY_D/BUSY_IF -> RESP -> IDLE.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                bus_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready
);
    localparam int BE_W = DATA_W / 8;
    localparam int SC_W = $clog2(STARVE_LIM + 1);
    localparam int TC_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY_D  = 2'd1;
    localparam logic [1:0] S_BUSY_IF = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mreq_t;

    logic [1:0]        state;
    logic [SC_W-1:0]   starve_cnt;
    logic [TC_W-1:0]   tmo_cnt;
    logic              drop;
    logic              err;
    logic              owner_if;
    logic [DATA_W-1:0] rdata_q;
    mreq_t             req_q;
    mreq_t             gnt_req;

    logic fetch_ok, fetch_forced, grant_d, grant_if, busy, tmo_hit, resp;

    // A flushing fetch is invisible to arbitration in that cycle.
    assign fetch_ok     = if_req && !if_flush;
    assign fetch_forced = fetch_ok && (starve_cnt == SC_W'(STARVE_LIM));
    assign grant_d      = (state == S_IDLE) && d_req && !fetch_forced;
    assign grant_if     = (state == S_IDLE) && fetch_ok && !grant_d;
    assign busy         = (state == S_BUSY_D) || (state == S_BUSY_IF);
    assign tmo_hit      = busy && !mem_ready && (tmo_cnt == TC_W'(TIMEOUT - 1));
    assign resp         = (state == S_RESP);

    always_comb begin
        gnt_req = '0;
        if (grant_d) begin
            gnt_req.we    = d_we;
            gnt_req.addr  = d_addr;
            gnt_req.wdata = d_wdata;
            gnt_req.be    = d_be;
        end else begin
            gnt_req.addr  = if_addr;
            gnt_req.be    = '1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            drop       <= 1'b0;
            err        <= 1'b0;
            owner_if   <= 1'b0;
            rdata_q    <= '0;
            req_q      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tmo_cnt <= '0;
                    err     <= 1'b0;
                    if (grant_d || grant_if) begin
                        state    <= grant_d ? S_BUSY_D : S_BUSY_IF;
                        owner_if <= grant_if;
                        req_q    <= gnt_req;
                    end
                end
                S_BUSY_D, S_BUSY_IF: begin
                    // A flushed fetch still runs to completion on the memory side.
                    if (state == S_BUSY_IF && if_flush) drop <= 1'b1;
                    if (!mem_ready) tmo_cnt <= tmo_cnt + 1'b1;
                    if (mem_ready) begin
                        state   <= S_RESP;
                        rdata_q <= mem_rdata;
                    end else if (tmo_hit) begin
                        state   <= S_RESP;
                        err     <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    drop  <= 1'b0;
                end
            endcase

            if (!if_req || grant_if)
                starve_cnt <= '0;
            else if (grant_d && starve_cnt != SC_W'(STARVE_LIM))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign mem_req   = busy;
    assign mem_we    = req_q.we;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign mem_be    = req_q.be;

    // Flush arriving during RESP still has to kill the fetch ack in that same cycle.
    assign if_ack   = resp && owner_if && !drop && !if_flush;
    assign d_ack    = resp && !owner_if;
    assign bus_err  = err && (if_ack || d_ack);
    assign if_rdata = rdata_q;
    assign d_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences, and a
// randomized run checked against a timestamp-based transaction model.
module tb_mem_port_arbiter;
    localparam int SLIM = 4;
    localparam int TMO  = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0, if_flush = 1'b0, if_ack;
    logic [31:0] if_addr = '0, if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0, d_ack;
    logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
    logic [3:0]  d_be = '0;
    logic        bus_err, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(SLIM), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    logic [31:0] memv [logic [31:0]];
    int          mem_cnt = 0;
    int          cur_lat = 0;
    logic        prev_mreq = 1'b0;
    logic [31:0] grants [$];

    function automatic logic [31:0] mread(input logic [31:0] a);
        return memv.exists(a) ? memv[a] : {a[15:0] ^ 16'h5a5a, a[15:0]};
    endfunction

    task automatic mem_step();
        logic [31:0] w;
        if (mem_req && !prev_mreq) grants.push_back(mem_addr);
        prev_mreq = mem_req;
        if (mem_req) begin
            if (mem_cnt == cur_lat) begin
                mem_ready = 1'b1;
                mem_rdata = mread(mem_addr);
                if (mem_we) begin
                    w = mem_rdata;
                    for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                    memv[mem_addr] = w;
                end
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
            mem_cnt++;
        end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            mem_cnt = 0;
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // Each grant is turned into absolute cycle stamps: mem_req over [m_start, m_resp), ack at m_resp.
    bit          model_on = 1'b0;
    int          cyc = 0;
    int          m_start = 0, m_resp = -1, m_starve = 0;
    bit          m_if = 1'b0, m_drop = 1'b0, m_err = 1'b0, m_we = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic [3:0]  m_be = '0;

    task automatic model_update();
        bit idle, fok, gd, gi;
        int lat, r;
        idle = (cyc > m_resp);
        fok  = if_req && !if_flush;
        gd   = idle && d_req && !(fok && m_starve == SLIM);
        gi   = idle && fok && !gd;
        if (!if_req || gi) m_starve = 0;
        else if (gd && m_starve < SLIM) m_starve++;
        if (m_if && cyc >= m_start && cyc < m_resp && if_flush) m_drop = 1'b1;
        if (gd || gi) begin
            r = $urandom_range(19);
            lat = (r == 0) ? 20 : (r == 1) ? 14 : (r == 2) ? 15 : r % 4;
            cur_lat = lat;
            m_if    = gi;
            m_drop  = 1'b0;
            m_start = cyc + 1;
            m_resp  = m_start + ((lat + 1 < TMO) ? lat + 1 : TMO);
            m_err   = (lat >= TMO);
            m_we    = gd ? d_we : 1'b0;
            m_addr  = gd ? d_addr : if_addr;
            m_wdata = d_wdata;
            m_be    = gd ? d_be : 4'hF;
            m_rdata = m_err ? 32'h0 : mread(m_addr);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (model_on) model_update();
        cyc++;
        @(negedge clk);
        mem_step();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          is_if;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          lat;
        int          flush_at;
        int          exp_ack;
        int          exp_busy;
        bit          exp_err;
        bit          chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [10];

    task automatic run_vec(input vec_t v, input int idx);
        int ack_at, nacks, busy, first;
        logic err;
        logic [31:0] rd;
        ack_at = -1; nacks = 0; busy = 0; first = -1; err = 1'b0; rd = '0;
        cur_lat = v.lat;
        if (v.is_if) begin
            if_req = 1'b1; if_addr = v.addr;
        end else begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
        end
        for (int c = 1; c <= 24; c++) begin
            tick();
            if_flush = (c == v.flush_at);
            if (if_flush) if_req = 1'b0;
            #1;
            if (mem_req) begin
                busy++;
                if (first < 0) begin
                    first = c;
                    chk($sformatf("vec%0d_addr", idx), mem_addr, v.addr);
                    chk($sformatf("vec%0d_be", idx), 32'(mem_be), v.is_if ? 32'hF : 32'(v.be));
                    chk($sformatf("vec%0d_we", idx), 32'(mem_we), 32'(v.we));
                    if (v.we) chk($sformatf("vec%0d_wdata", idx), mem_wdata, v.wdata);
                end
            end
            if (if_ack || d_ack) begin
                nacks++;
                ack_at = c;
                err = bus_err;
                rd = v.is_if ? if_rdata : d_rdata;
                if_req = 1'b0;
                d_req = 1'b0;
            end
        end
        if_flush = 1'b0;
        chk($sformatf("vec%0d_grant_cycle", idx), 32'(first), 32'd1);
        chk($sformatf("vec%0d_busy_cycles", idx), 32'(busy), 32'(v.exp_busy));
        chk($sformatf("vec%0d_ack_cycle", idx), 32'(ack_at), 32'(v.exp_ack));
        chk($sformatf("vec%0d_ack_count", idx), 32'(nacks), (v.exp_ack < 0) ? 32'd0 : 32'd1);
        if (v.exp_ack >= 0) chk($sformatf("vec%0d_bus_err", idx), 32'(err), 32'(v.exp_err));
        if (v.chk_rd) chk($sformatf("vec%0d_rdata", idx), rd, v.exp_rd);
    endtask

    initial begin
        int nd, nbad;
        logic [31:0] exp_g [6];
        bit prev_dack, prev_iack, prev_flush, e_mreq, e_resp, e_ia, e_da;
        logic [31:0] pc;

        memv[32'h100]  = 32'h00500093;
        memv[32'h108]  = 32'h00000013;
        memv[32'h10C]  = 32'h00A00113;
        memv[32'h2000] = 32'hDEADBEEF;
        memv[32'h2004] = 32'h11223344;

        // is_if we addr wdata be lat flush_at exp_ack exp_busy exp_err chk_rd exp_rd
        vecs[0] = '{1'b1, 1'b0, 32'h100,  32'h0,    4'hF, 0,  -1, 2,  1,  1'b0, 1'b1, 32'h00500093};
        vecs[1] = '{1'b0, 1'b0, 32'h2000, 32'h0,    4'hF, 2,  -1, 4,  3,  1'b0, 1'b1, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 32'h2000, 32'hAB00, 4'h2, 1,  -1, 3,  2,  1'b0, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h2000, 32'h0,    4'hF, 0,  -1, 2,  1,  1'b0, 1'b1, 32'hDEADABEF};
        vecs[4] = '{1'b0, 1'b1, 32'h2004, 32'hAB00, 4'h2, 99, -1, 16, 15, 1'b1, 1'b1, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 32'h2004, 32'h0,    4'hF, 14, -1, 16, 15, 1'b0, 1'b1, 32'h11223344};
        vecs[6] = '{1'b0, 1'b0, 32'h2008, 32'h0,    4'hF, 15, -1, 16, 15, 1'b1, 1'b1, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 32'h104,  32'h0,    4'hF, 3,  2,  -1, 4,  1'b0, 1'b0, 32'h0};
        vecs[8] = '{1'b1, 1'b0, 32'h108,  32'h0,    4'hF, 0,  -1, 2,  1,  1'b0, 1'b1, 32'h00000013};
        vecs[9] = '{1'b1, 1'b0, 32'h10C,  32'h0,    4'hF, 1,  -1, 3,  2,  1'b0, 1'b1, 32'h00A00113};

        // Reset state
        @(negedge clk); @(negedge clk); #1;
        chk("reset_ctrl", {27'b0, mem_req, mem_we, if_ack, d_ack, bus_err}, 32'h0);
        chk("reset_addr", mem_addr, 32'h0);
        chk("reset_rdata", if_rdata | d_rdata | mem_wdata | 32'(mem_be), 32'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Contention: data first, fetch after d_ack
        grants.delete();
        cur_lat = 0;
        if_req = 1'b1; if_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_be = 4'hF;
        for (int c = 1; c <= 12; c++) begin
            tick(); #1;
            if (d_ack) d_req = 1'b0;
            if (if_ack) if_req = 1'b0;
        end
        chk("contend_grants", 32'(grants.size()), 32'd2);
        if (grants.size() == 2) begin
            chk("contend_first", grants[0], 32'h2000);
            chk("contend_second", grants[1], 32'h300);
        end

        // Starvation: 4 data grants then fetch is forced
        grants.delete();
        nd = 0;
        if_req = 1'b1; if_addr = 32'h400;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_be = 4'hF;
        for (int c = 1; c <= 60; c++) begin
            tick(); #1;
            if (d_ack) begin
                nd++;
                d_addr = d_addr + 32'd4;
                if (nd == 5) d_req = 1'b0;
            end
            if (if_ack) if_req = 1'b0;
        end
        exp_g = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h400, 32'h3010};
        chk("starve_grants", 32'(grants.size()), 32'd6);
        for (int k = 0; k < 6; k++)
            if (k < grants.size()) chk($sformatf("starve_grant%0d", k), grants[k], exp_g[k]);

        // Flush during RESP suppresses the fetch ack
        cur_lat = 0;
        if_req = 1'b1; if_addr = 32'h500;
        tick(); #1;
        chk("rflush_busy", 32'(mem_req), 32'd1);
        tick();
        if_flush = 1'b1; #1;
        chk("rflush_no_ack", 32'(if_ack), 32'd0);
        if_flush = 1'b0; if_req = 1'b0;
        tick(); tick();

        // Reset during BUSY_D
        cur_lat = 5;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_be = 4'hF;
        tick(); tick(); #1;
        chk("rst_pre_busy", 32'(mem_req), 32'd1);
        reset = 1'b1; #1;
        chk("rst_outputs", {28'b0, mem_req, d_ack, if_ack, bus_err}, 32'h0);
        d_req = 1'b0;
        tick();
        reset = 1'b0;
        nbad = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 2) begin mem_ready = 1'b1; mem_rdata = 32'hBAD0BAD0; end
            #1;
            if (d_ack || if_ack || mem_req || bus_err) nbad++;
        end
        chk("rst_no_late_ack", 32'(nbad), 32'd0);

        // Randomized run against the model
        reset = 1'b1; #1;
        tick();
        reset = 1'b0;
        m_start = 0; m_resp = -1; m_starve = 0; m_if = 1'b0; m_drop = 1'b0;
        m_err = 1'b0; m_we = 1'b0; m_addr = '0; m_be = '0;
        prev_dack = 1'b0; prev_iack = 1'b0; prev_flush = 1'b0;
        pc = 32'h1000;
        model_on = 1'b1;
        for (int n = 0; n < 800; n++) begin
            tick();
            if_flush = 1'b0;
            if (d_req && prev_dack) d_req = 1'b0;
            if (!d_req && $urandom_range(2) == 0) begin
                d_req = 1'b1;
                d_we = 1'($urandom_range(1));
                d_addr = 32'h2000 + 32'(4 * $urandom_range(7));
                d_wdata = $urandom;
                d_be = 4'($urandom_range(15));
            end
            if (if_req && (prev_iack || prev_flush)) if_req = 1'b0;
            if (!if_req && $urandom_range(1) == 0) begin
                if_req = 1'b1; if_addr = pc; pc = pc + 32'd4;
            end
            if ($urandom_range(9) == 0) if_flush = 1'b1;
            #1;
            e_mreq = (cyc >= m_start) && (cyc < m_resp);
            e_resp = (cyc == m_resp);
            e_ia   = e_resp && m_if && !m_drop && !if_flush;
            e_da   = e_resp && !m_if;
            chk("rnd_mem_req", 32'(mem_req), 32'(e_mreq));
            if (e_mreq) begin
                chk("rnd_mem_addr", mem_addr, m_addr);
                chk("rnd_mem_we", 32'(mem_we), 32'(m_we));
                chk("rnd_mem_be", 32'(mem_be), 32'(m_be));
                if (m_we) chk("rnd_mem_wdata", mem_wdata, m_wdata);
            end
            chk("rnd_if_ack", 32'(if_ack), 32'(e_ia));
            chk("rnd_d_ack", 32'(d_ack), 32'(e_da));
            chk("rnd_bus_err", 32'(bus_err), 32'((e_ia || e_da) && m_err));
            if (e_ia) chk("rnd_if_rdata", if_rdata, m_rdata);
            if (e_da && (!m_we || m_err)) chk("rnd_d_rdata", d_rdata, m_rdata);
            prev_dack  = d_ack;
            prev_iack  = if_ack;
            prev_flush = if_flush;
        end
        model_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
